jk_updown_counter_ctrl: RTL and testbench

- Synchronous modulo-N up/down counter with load.
- Computes per-bit J/K excitation each cycle, so a bank of negative-edge JK flip-flops can be driven directly. Sits directly upstream of that bank.
- Keeps an internal shadow copy of the count state, so the counter value and terminal-count flag are available without external feedback.
- Updates on the falling clock edge, matching the JK flip-flop stage it feeds.

---
 rtl/jk_updown_counter_ctrl.sv | 123 ++++++++++++
 tb/tb_jk_updown_counter_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/jk_updown_counter_ctrl.sv
// Modulo-N up/down counter with load that drives a falling-edge JK flip-flop bank.
// Define JK_COUNTER_SATURATE_EN to make the counter saturate at its bounds instead of wrapping.

package jk_updown_counter_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_CLEAR = 2'd3
  } exc_mode_e;
endpackage

// Excitation for one JK bit. Clear resets the bit, load sets or resets it,
// count toggles it only when it changes, and hold leaves it alone.
module jk_exc_bit
  import jk_updown_counter_ctrl_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       qb,
  input  logic       nqb,
  input  logic       dinb,
  output logic       j,
  output logic       k
);
  always_comb begin
    j = 1'b0;
    k = 1'b0;
    case (mode)
      MODE_CLEAR: k = 1'b1;
      MODE_LOAD: begin
        j = dinb;
        k = ~dinb;
      end
      MODE_COUNT: begin
        j = qb ^ nqb;
        k = qb ^ nqb;
      end
      default: ;
    endcase
  end
endmodule

module jk_updown_counter_ctrl
  import jk_updown_counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] j_exc,
  output logic [WIDTH-1:0] k_exc
);
  localparam logic [WIDTH-1:0] MAXV = (WIDTH)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = (WIDTH)'(1);

  exc_mode_e        mode;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] nq;
  logic             at_top;
  logic             at_bot;

  // Out-of-range values count as being at the top, so counting up from them wraps or saturates.
  assign at_top = (q_r >= MAXV);
  assign at_bot = (q_r == '0);

  always_comb begin
    mode = MODE_HOLD;
    if (clear)     mode = MODE_CLEAR;
    else if (load) mode = MODE_LOAD;
    else if (en)   mode = MODE_COUNT;
  end

  always_comb begin
    nq = q_r;
    case (mode)
      MODE_CLEAR: nq = '0;
      MODE_LOAD:  nq = din;
      MODE_COUNT: begin
        if (up) begin
`ifdef JK_COUNTER_SATURATE_EN
          nq = at_top ? MAXV : q_r + ONE;
`else
          nq = at_top ? '0 : q_r + ONE;
`endif
        end else begin
`ifdef JK_COUNTER_SATURATE_EN
          nq = at_bot ? '0 : q_r - ONE;
`else
          nq = at_bot ? MAXV : q_r - ONE;
`endif
        end
      end
      default: ;
    endcase
  end

  // Shadow state updates on the same falling edge as the external JK bank.
  always_ff @(negedge clk or posedge clear) begin
    if (clear) q_r <= '0;
    else       q_r <= nq;
  end

  assign q  = q_r;
  assign tc = (mode == MODE_COUNT) & (up ? at_top : at_bot);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_exc_bit u_bit (
      .mode (mode),
      .qb   (q_r[i]),
      .nqb  (nq[i]),
      .dinb (din[i]),
      .j    (j_exc[i]),
      .k    (k_exc[i])
    );
  end
endmodule

// File: tb/tb_jk_updown_counter_ctrl.sv
// Bench for jk_updown_counter_ctrl using directed vectors (WIDTH=4, MODULUS=10).
// Each table row sets the inputs for one falling edge and gives the outputs expected after that edge.
module tb_jk_updown_counter_ctrl;
  logic       clk, clear, en, up, load;
  logic [3:0] din, q, j_exc, k_exc;
  logic       tc;

  int n_cmp = 0;
  int n_bad = 0;

  jk_updown_counter_ctrl #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din),
    .q(q), .tc(tc), .j_exc(j_exc), .k_exc(k_exc)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr, ld, en, up;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc;
    logic [3:0] j, k;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic c, logic l, logic e, logic u, logic [3:0] d,
                              logic [3:0] eq, logic et, logic [3:0] ej, logic [3:0] ek);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.up = u; v.din = d;
    v.q = eq; v.tc = et; v.j = ej; v.k = ek;
    tbl.push_back(v);
  endfunction

  // Count rows, where j and k are expected to be equal.
  function automatic void cnt(logic u, logic [3:0] eq, logic et, logic [3:0] ejk);
    add(1'b0, 1'b0, 1'b1, u, 4'h0, eq, et, ejk, ejk);
  endfunction

  // Load rows: with load held, the excitation is din and ~din, and tc stays low.
  function automatic void ldr(logic e, logic u, logic [3:0] d);
    add(1'b0, 1'b1, e, u, d, d, 1'b0, d, ~d);
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      clear = tbl[i].clr; load = tbl[i].ld; en = tbl[i].en;
      up = tbl[i].up; din = tbl[i].din;
      @(negedge clk);
      @(posedge clk);
      chk($sformatf("row%0d.q", i), q, tbl[i].q);
      chk($sformatf("row%0d.tc", i), {3'b0, tc}, {3'b0, tbl[i].tc});
      chk($sformatf("row%0d.j", i), j_exc, tbl[i].j);
      chk($sformatf("row%0d.k", i), k_exc, tbl[i].k);
    end
  endtask

  int s1, s2, s3, s4;

  initial begin
    clear = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1; din = 4'h0;

    // Segment 1: count up 12 edges from reset.
    cnt(1, 4'd1, 0, 4'h3); cnt(1, 4'd2, 0, 4'h1); cnt(1, 4'd3, 0, 4'h7);
    cnt(1, 4'd4, 0, 4'h1); cnt(1, 4'd5, 0, 4'h3); cnt(1, 4'd6, 0, 4'h1);
    cnt(1, 4'd7, 0, 4'hF); cnt(1, 4'd8, 0, 4'h1);
`ifdef JK_COUNTER_SATURATE_EN
    cnt(1, 4'd9, 1, 4'h0); cnt(1, 4'd9, 1, 4'h0);
    cnt(1, 4'd9, 1, 4'h0); cnt(1, 4'd9, 1, 4'h0);
`else
    cnt(1, 4'd9, 1, 4'h9); cnt(1, 4'd0, 0, 4'h1);
    cnt(1, 4'd1, 0, 4'h3); cnt(1, 4'd2, 0, 4'h1);
`endif
    // Load 3, then count down 4 edges.
    ldr(0, 0, 4'd3);
    cnt(0, 4'd2, 0, 4'h3); cnt(0, 4'd1, 0, 4'h1);
`ifdef JK_COUNTER_SATURATE_EN
    cnt(0, 4'd0, 1, 4'h0); cnt(0, 4'd0, 1, 4'h0);
`else
    cnt(0, 4'd0, 1, 4'h9); cnt(0, 4'd9, 0, 4'h1);
`endif
    // Hold at 5 for three edges, then load 6 ahead of the asynchronous clear.
    ldr(0, 0, 4'd5);
    add(0, 0, 0, 1, 4'h0, 4'd5, 0, 4'h0, 4'h0);
    add(0, 0, 0, 0, 4'h0, 4'd5, 0, 4'h0, 4'h0);
    add(0, 0, 0, 1, 4'h0, 4'd5, 0, 4'h0, 4'h0);
    ldr(0, 0, 4'd6);
    s1 = tbl.size();
    // Segment 2: an out-of-range load wins over counting, then wraps or decrements.
    ldr(1, 1, 4'd13);
`ifdef JK_COUNTER_SATURATE_EN
    cnt(1, 4'd9, 1, 4'h0);
`else
    cnt(1, 4'd0, 0, 4'h1);
`endif
    ldr(1, 0, 4'd13);
    cnt(0, 4'd12, 0, 4'h7);
    ldr(0, 0, 4'd4);
    s2 = tbl.size();
    // Segment 3: boundary behaviour from 8 going up and from 1 going down.
    ldr(0, 0, 4'd8);
`ifdef JK_COUNTER_SATURATE_EN
    cnt(1, 4'd9, 1, 4'h0); cnt(1, 4'd9, 1, 4'h0); cnt(1, 4'd9, 1, 4'h0);
    ldr(0, 0, 4'd1);
    cnt(0, 4'd0, 1, 4'h0); cnt(0, 4'd0, 1, 4'h0);
`else
    cnt(1, 4'd9, 1, 4'h9); cnt(1, 4'd0, 0, 4'h1); cnt(1, 4'd1, 0, 4'h3);
    ldr(0, 0, 4'd1);
    cnt(0, 4'd0, 1, 4'h9); cnt(0, 4'd9, 0, 4'h1);
`endif
    s3 = tbl.size();
    s4 = s3;

    // Reset state: clear dominates even with en=1 and up=1 applied.
    #1;
    chk("reset.q", q, 4'h0);
    chk("reset.j", j_exc, 4'h0);
    chk("reset.k", k_exc, 4'hF);
    chk("reset.tc", {3'b0, tc}, 4'h0);
    @(posedge clk);

    run(0, s1);

    // Asynchronous clear between edges, starting from q=6.
    clear = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    #2 clear = 1'b1;
    #1;
    chk("aclr.q", q, 4'h0);
    chk("aclr.j", j_exc, 4'h0);
    chk("aclr.k", k_exc, 4'hF);
    chk("aclr.tc", {3'b0, tc}, 4'h0);
    @(negedge clk); @(posedge clk);
    chk("aclr.held", q, 4'h0);
    clear = 1'b0;
    #1 chk("aclr.release", q, 4'h0);
    @(negedge clk); @(posedge clk);
    chk("aclr.first_edge", q, 4'h1);

    run(s1, s2);

    // The direction is sampled at the falling edge: up changes 0->1 mid-cycle at q=4.
    load = 1'b0; en = 1'b1; up = 1'b0;
    #2 up = 1'b1;
    @(negedge clk); @(posedge clk);
    chk("upchg.q", q, 4'h5);

    run(s2, s4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
